fetch_stage: RTL

- Instruction fetch stage; sits directly upstream of the decode stage and drives its `Instruccion` input.
- Owns the program counter and issues in-order requests to a variable-latency instruction memory.
- Buffers returned words in a small prefetch FIFO tagged with their PC, and presents them to decode under a stall signal.
- Handles branch/jump redirects from execute (opcodes 7 `b` and 8 `beg`) by flushing and discarding stale in-flight responses.

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response channel plus the
// decode-facing instruction port and execute-side redirect/stall controls.
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       Instruccion;
    logic              instr_valid;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, Instruccion, instr_valid, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, Instruccion, instr_valid, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC owner, credit-limited in-order memory requests,
// PC-tagged prefetch FIFO toward decode, redirect flush with stale-response drop.
module fetch_stage_chk #(
    parameter int CNT_W = 2
) (
    input logic             clock,
    input logic             reset,
    input logic             rvalid,
    input logic [CNT_W-1:0] outst
);
    // A response with nothing outstanding is a memory protocol violation.
    rvalid_needs_outstanding: assert property (
        @(posedge clock) disable iff (!reset) !(rvalid && (outst == {CNT_W{1'b0}}))
    ) else $error("imem_rvalid asserted with no outstanding request");
endmodule

module fetch_stage #(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] PC_STEP  = {{(ADDR_W-1){1'b0}}, 1'b1},
    parameter int              FIFO_DEPTH = 2
) (
    input logic          clock,
    input logic          reset,
    fetch_stage_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [ADDR_W-1:0] infl_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]  infl_rd_q, infl_rd_d, infl_wr_q, infl_wr_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic              rsp_s, req_s, hs_s, keep_s, drop_s, pop_s;
    logic [OCC_W-1:0]  occ_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Event decode: credit-gated issue, response capture/drop, decode pop.
    always_comb begin
        occ_s  = OCC_W'(fifo_cnt_q) + OCC_W'(outst_q);
        rsp_s  = bus.imem_rvalid && (outst_q != {CNT_W{1'b0}});
        req_s  = (state_q == ST_RUN) && !bus.redirect && (occ_s < OCC_W'(FIFO_DEPTH));
        hs_s   = req_s && bus.imem_ready;
        keep_s = rsp_s && (discard_q == {CNT_W{1'b0}}) && !bus.redirect;
        drop_s = rsp_s && (discard_q != {CNT_W{1'b0}});
        pop_s  = (fifo_cnt_q != {CNT_W{1'b0}}) && !bus.stall && !bus.redirect;
    end

    // Datapath next state; a redirect clears the FIFO, and every request still
    // in flight after this cycle belongs to the abandoned path.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_cnt_d = fifo_cnt_q;
        discard_d  = discard_q;
        infl_rd_d  = rsp_s ? ptr_inc(infl_rd_q) : infl_rd_q;
        infl_wr_d  = hs_s  ? ptr_inc(infl_wr_q) : infl_wr_q;
        outst_d    = outst_q + CNT_W'(hs_s) - CNT_W'(rsp_s);
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            fifo_rd_d  = {PTR_W{1'b0}};
            fifo_wr_d  = {PTR_W{1'b0}};
            fifo_cnt_d = {CNT_W{1'b0}};
            discard_d  = outst_q - CNT_W'(rsp_s);
        end else begin
            fetch_pc_d = hs_s   ? (fetch_pc_q + PC_STEP) : fetch_pc_q;
            fifo_rd_d  = pop_s  ? ptr_inc(fifo_rd_q) : fifo_rd_q;
            fifo_wr_d  = keep_s ? ptr_inc(fifo_wr_q) : fifo_wr_q;
            fifo_cnt_d = fifo_cnt_q + CNT_W'(keep_s) - CNT_W'(pop_s);
            discard_d  = discard_q - CNT_W'(drop_s);
        end
    end

    // Datapath registers and storage arrays.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            fifo_rd_q  <= {PTR_W{1'b0}};
            fifo_wr_q  <= {PTR_W{1'b0}};
            fifo_cnt_q <= {CNT_W{1'b0}};
            infl_rd_q  <= {PTR_W{1'b0}};
            infl_wr_q  <= {PTR_W{1'b0}};
            outst_q    <= {CNT_W{1'b0}};
            discard_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= {ADDR_W{1'b0}};
                fifo_data_q[i] <= 32'h0000_0000;
                infl_pc_q[i]   <= {ADDR_W{1'b0}};
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            infl_rd_q  <= infl_rd_d;
            infl_wr_q  <= infl_wr_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            if (keep_s) begin
                fifo_pc_q[fifo_wr_q]   <= infl_pc_q[infl_rd_q];
                fifo_data_q[fifo_wr_q] <= bus.imem_rdata;
            end
            if (hs_s) begin
                infl_pc_q[infl_wr_q] <= fetch_pc_q;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect overrides; DRAIN holds until stale words are gone.
    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = (discard_d != {CNT_W{1'b0}}) ? ST_DRAIN : ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                ST_DRAIN: state_d = (discard_d == {CNT_W{1'b0}}) ? ST_RUN : ST_DRAIN;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    // Outputs: request from FSM/credit, decode port shows the FIFO head or zero.
    always_comb begin
        bus.imem_req    = req_s;
        bus.imem_addr   = fetch_pc_q;
        bus.instr_valid = (fifo_cnt_q != {CNT_W{1'b0}});
        if (fifo_cnt_q != {CNT_W{1'b0}}) begin
            bus.Instruccion = fifo_data_q[fifo_rd_q];
            bus.instr_pc    = fifo_pc_q[fifo_rd_q];
        end else begin
            bus.Instruccion = 32'h0000_0000;
            bus.instr_pc    = {ADDR_W{1'b0}};
        end
    end

`ifndef SYNTHESIS
    fetch_stage_chk #(.CNT_W(CNT_W)) u_chk (
        .clock  (clock),
        .reset  (reset),
        .rvalid (bus.imem_rvalid),
        .outst  (outst_q)
    );
`endif
endmodule
